// File: rtl/mmio_slot_arbiter.sv
// Round-robin arbiter sharing one MMIO slot among NUM_REQ masters.
// Latches the winner's command, runs the slot handshake, returns status.
module mmio_slot_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IW            = $clog2(NUM_REQ),
  localparam int CW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*8-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_slave_error,
  output logic                  resp_decode_error,
  output logic                  resp_timeout,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  chip_select,
  output logic                  read,
  output logic                  write,
  output logic [7:0]            addr,
  output logic [31:0]           wr_data,
  output logic                  transaction_completed,
  input  logic [31:0]           rd_data,
  input  logic                  wr_done,
  input  logic                  rd_done,
  input  logic                  slave_error,
  input  logic                  decode_error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [CW-1:0] cnt;
  logic [IW-1:0] win;
  logic          found;
  int            idx;
  logic          done;

  assign done = rd_done | wr_done;

  // First requester after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Grant / slot handshake / completion state machine.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state                 <= IDLE;
      last                  <= IW'(NUM_REQ - 1);
      cnt                   <= '0;
      resp_valid            <= '0;
      resp_rdata            <= '0;
      resp_slave_error      <= 1'b0;
      resp_decode_error     <= 1'b0;
      resp_timeout          <= 1'b0;
      busy                  <= 1'b0;
      grant_id              <= '0;
      chip_select           <= 1'b0;
      read                  <= 1'b0;
      write                 <= 1'b0;
      addr                  <= '0;
      wr_data               <= '0;
      transaction_completed <= 1'b0;
    end else begin
      resp_valid            <= '0;
      transaction_completed <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id    <= win;
            addr        <= req_addr[8*int'(win) +: 8];
            wr_data     <= req_wdata[32*int'(win) +: 32];
            chip_select <= 1'b1;
            read        <= !req_write[win];
            write       <= req_write[win];
            last        <= win;
            busy        <= 1'b1;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            resp_rdata            <= write ? 32'd0 : rd_data;
            resp_slave_error      <= slave_error;
            resp_decode_error     <= decode_error;
            resp_timeout          <= 1'b0;
            chip_select           <= 1'b0;
            read                  <= 1'b0;
            write                 <= 1'b0;
            resp_valid            <= NUM_REQ'(1) << grant_id;
            transaction_completed <= 1'b1;
            state                 <= COMPLETE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            resp_rdata            <= '0;
            resp_slave_error      <= 1'b0;
            resp_decode_error     <= 1'b0;
            resp_timeout          <= 1'b1;
            chip_select           <= 1'b0;
            read                  <= 1'b0;
            write                 <= 1'b0;
            resp_valid            <= NUM_REQ'(1) << grant_id;
            transaction_completed <= 1'b1;
            state                 <= COMPLETE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPLETE: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmio_slot_arbiter.md
Name: mmio_slot_arbiter

Overview:
- Round-robin arbiter that shares one MMIO slot (e.g. the GPIO or timer slot) between NUM_REQ masters, such as CPU load/store and a debug/DMA port.
- Per granted request it latches the command and drives the slot handshake: chip_select plus read/write until rd_done/wr_done, then a one-cycle transaction_completed.
- Returns read data and error status to the granted master.
- A timeout guard keeps a dead slave from hanging the arbiter.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 16, max cycles in BUSY without rd_done/wr_done before the arbiter aborts (≥4).

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-master request; held with its fields until that master's resp_valid
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*8  packed addresses, master i at [8i+7:8i]
- req_wdata  in  NUM_REQ*32  packed write data, master i at [32i+31:32i]
- resp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted master
- resp_rdata  out  32  read data; valid with resp_valid
- resp_slave_error  out  1  slave_error captured at done
- resp_decode_error  out  1  decode_error captured at done
- resp_timeout  out  1  transaction aborted by timeout
- busy  out  1  high in BUSY and COMPLETE
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted master
- chip_select  out  1  slot select
- read  out  1  slot read strobe
- write  out  1  slot write strobe
- addr  out  8  slot address
- wr_data  out  32  slot write data
- transaction_completed  out  1  one-cycle release pulse to the slave
- rd_data  in  32  slot read data
- wr_done  in  1  slot write done
- rd_done  in  1  slot read done
- slave_error  in  1  slot illegal-access flag
- decode_error  in  1  slot bad-address flag

Behaviour:
- All outputs are registered.
- Reset: every output is 0 and state=IDLE. The round-robin pointer last=NUM_REQ-1, so master 0 has highest priority first. Timeout counter is 0.
- Reset asserted mid-transaction aborts it with no resp_valid. The slave is reset by the same arst_n.
- FSM: IDLE -> BUSY -> COMPLETE -> IDLE.
- IDLE, any req_valid set:
  - Pick the first set bit searching from last+1 with wrap-around.
  - Register grant_id, addr, wr_data and read/write from the winner.
  - Set chip_select=1, read=!req_write, write=req_write.
  - Update last to the winner; go to BUSY.
  - Only one winner per grant.
  - A request arriving while busy waits; no starvation, because each master gets a turn within NUM_REQ grants.
- BUSY:
  - chip_select/read/write/addr/wr_data are held stable.
  - The counter increments each cycle.
  - On (rd_done|wr_done):
    - Capture rd_data (forced 0 for writes), slave_error and decode_error.
    - Drop chip_select/read/write to 0.
    - Next cycle: resp_valid[grant_id]=1 and transaction_completed=1. Go to COMPLETE.
  - If the counter reaches TIMEOUT_CYCLES with no done, take the same exit with resp_timeout=1, rdata=0 and errors 0.
  - done arriving in the same cycle the timeout expires counts as done, not timeout.
- COMPLETE:
  - One cycle; resp_valid and transaction_completed are high only here.
  - resp_rdata and the error/timeout flags hold their values until the next capture.
  - Counter clears; go to IDLE.
  - A request can be granted in the IDLE cycle immediately after.
- Latency, for a slave with 2-cycle turnaround:
  - req sampled in IDLE at cycle 0.
  - chip_select high at cycles 1-3.
  - done seen at cycle 3.
  - resp_valid and transaction_completed at cycle 4.
  - Next grant sampled at cycle 5.
- Protocol rules:
  - A master dropping req_valid after grant is ignored; the transaction completes and resp_valid still pulses.
  - req fields of non-granted masters are don't-care.
  - Stray done while IDLE/COMPLETE is ignored.
  - Both rd_done and wr_done high counts as a single done.

Test Plan:
- Single read: master0 read addr 0x10, slave returns rd_data=1 → chip_select cycles 1-3, resp_valid=2'b01 at cycle 4, resp_rdata=1, transaction_completed pulse at cycle 4, errors 0.
- Single write: master1 writes 0x0F to addr 0x0C → write=1, wr_data=0x0F on slot, resp_valid=2'b10, resp_rdata=0, no errors.
- Round robin: both masters request continuously for 4 transactions → grant_id order 0,1,0,1, one resp_valid per transaction, never both bits set.
- Error passthrough:
  - read of addr 0x00 → resp_slave_error=1.
  - write of addr 0x40 → resp_decode_error=1.
  - subsequent legal access → both flags 0.
- Timeout: slave never asserts done, TIMEOUT_CYCLES=16 → resp_timeout=1 after 16 BUSY cycles, resp_rdata=0, transaction_completed pulses, arbiter returns to IDLE and serves the next request.
- Reset mid-BUSY: assert arst_n low at cycle 2 of a read → all outputs 0 immediately, no resp_valid; after release, master 0 wins over simultaneous master 1.
